// File: rtl/rf_param.sv
// Parametrised register file: one write port, two registered read ports, bulk-clear engine.
// Latency: reads return one clk after the enable; clear takes DEPTH cycles plus one done cycle.
// Backpressure: none; writes during a clear are dropped and busy tells the writer to wait.
module rf_param #(
  parameter int DW       = 10,
  parameter int DEPTH    = 4,
  parameter int ZERO_REG = 0,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic          rae,
  input  logic [AW-1:0] raa,
  input  logic          rbe,
  input  logic [AW-1:0] rba,
  input  logic          clr_req,
  output logic [DW-1:0] aout,
  output logic [DW-1:0] bout,
  output logic          busy,
  output logic          clr_done
);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  // One extra bit so non-power-of-2 depths can be range-checked.
  localparam logic [AW:0]   DEPTH_W = DEPTH[AW:0];
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  state_t        state;
  logic [AW-1:0] idx;
  logic [DW-1:0] mem [DEPTH];

  logic          wa_ok;
  logic          wr_acc;
  logic [DW-1:0] a_val;
  logic [DW-1:0] b_val;

  // Value a read port would see this cycle, including same-cycle write bypass.
  function automatic logic [DW-1:0] rd_val(input logic [AW-1:0] x);
    logic [DW-1:0] v;
    v = '0;
    if ({1'b0, x} >= DEPTH_W) begin
      v = '0;
    end else if ((ZERO_REG != 0) && (x == '0)) begin
      v = '0;
    end else if (wr_acc && (wa == x)) begin
      v = wd;
    end else begin
      v = mem[x];
    end
    return v;
  endfunction

  // Decide whether the external write lands and what each read port will capture.
  always_comb begin
    wa_ok  = ({1'b0, wa} < DEPTH_W) && !((ZERO_REG != 0) && (wa == '0));
    wr_acc = we && !busy && wa_ok;
    a_val  = rd_val(raa);
    b_val  = rd_val(rba);
  end

  // Storage: the clear engine owns the array while it runs, otherwise accepted writes land.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (state == CLEAR) begin
      mem[idx] <= '0;
    end else if (wr_acc) begin
      mem[wa] <= wd;
    end
  end

  // Registered read ports; a disabled port holds its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aout <= '0;
      bout <= '0;
    end else begin
      if (rae) aout <= a_val;
      if (rbe) bout <= b_val;
    end
  end

  // Clear sequencer: walks idx 0..DEPTH-1, then a single done cycle before taking new requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      busy     <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          clr_done <= 1'b0;
          if (clr_req) begin
            state <= CLEAR;
            idx   <= '0;
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          if (idx == LAST) begin
            state    <= DONE;
            idx      <= '0;
            busy     <= 1'b0;
            clr_done <= 1'b1;
          end else begin
            idx <= idx + AW'(1);
          end
        end
        DONE: begin
          state    <= IDLE;
          clr_done <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          idx      <= '0;
          busy     <= 1'b0;
          clr_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/rf_param.md
Name: rf_param

Overview:
- Parametrised successor to the team's 4x10-bit register file; sits between the datapath ALU and the instruction decoder.
- One write port and two read ports (A/B).
- Read outputs are registered, with write-through bypass.
- Adds async reset, optional hardwired-zero register 0, and a sequenced bulk-clear engine with busy/done handshake.

Parameters:
- DW, 10, data width in bits.
- DEPTH, 4, number of registers (2..64; need not be a power of 2).
- ZERO_REG, 0, when 1, register 0 always reads 0 and writes to it are discarded.
- AW (localparam), clog2(DEPTH), address width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- we  input  1  write enable.
- wa  input  AW  write address.
- wd  input  DW  write data.
- rae  input  1  read port A enable.
- raa  input  AW  read port A address.
- rbe  input  1  read port B enable.
- rba  input  AW  read port B address.
- clr_req  input  1  bulk-clear request (level-sampled).
- aout  output  DW  read port A data (registered).
- bout  output  DW  read port B data (registered).
- busy  output  1  high while the clear engine runs.
- clr_done  output  1  one-cycle pulse when the clear completes.

Behaviour:
- Reset (rst_n=0, async): all registers, aout, bout, busy, clr_done = 0; clear index = 0; FSM = IDLE.
- Write: on a clk edge with we=1, busy=0, wa<DEPTH, and not (ZERO_REG=1 && wa=0): reg[wa] <= wd. All other writes are discarded silently.
- Read: 1-cycle latency. On a clk edge with rae=1: aout <= value(raa). With rae=0, aout holds its previous value. Port B is identical with rbe/rba/bout.
- value(x) priority, highest first:
  - x>=DEPTH -> 0.
  - ZERO_REG=1 and x=0 -> 0.
  - An accepted external write in the same cycle with wa==x -> wd (bypass).
  - Otherwise reg[x].
- Ports A and B may address the same register simultaneously; both return the same value.
- FSM states:
  - IDLE: busy=0. clr_req=1 at an edge -> CLEAR, idx<=0.
  - CLEAR: busy=1. Each cycle reg[idx] <= 0 and idx increments. When idx==DEPTH-1 is written -> DONE. Total DEPTH cycles in CLEAR.
  - DONE: busy=0, clr_done=1 for exactly this cycle, then -> IDLE. clr_req=1 in DONE is ignored; a new request is accepted only from IDLE.
- busy and clr_done are registered FSM decodes.
- During CLEAR:
  - External writes are dropped (not queued) and there is no bypass.
  - Reads remain legal and return current array contents. An entry being zeroed in that same cycle returns its pre-clear value; zero is visible from the next cycle.
- clr_req held high through the whole clear: only one clear executes; a second clear starts on the first edge in IDLE where clr_req=1.
- Reset asserted mid-clear aborts immediately. All state goes to the reset values and there is no clr_done pulse.
- No arithmetic besides the idx counter (AW bits). idx never exceeds DEPTH-1.

Test Plan:
- Write/read, DW=10, DEPTH=4: write 0x2A5->r1, 0x15A->r2; next cycle rae=1 raa=1, rbe=1 rba=2 -> one cycle later aout=0x2A5, bout=0x15A; drop rae/rbe and write r1=0x000 -> aout/bout hold.
- Bypass: same cycle we=1 wa=3 wd=0x3FF and rae=1 raa=3 (r3 previously 0x001) -> next edge aout=0x3FF.
- ZERO_REG=1: write 0x123->r0, then read r0 -> aout=0. Out-of-range (DEPTH=5, raa=7) -> 0; write to wa=7 changes no register.
- Bulk clear, DEPTH=4, all regs 0x3FF: pulse clr_req -> busy=1 for exactly 4 cycles, then clr_done=1 for 1 cycle, then all reads return 0. we=1 wd=0x111 during busy -> dropped, register stays 0.
- Reset mid-clear: assert rst_n=0 asynchronously on the 2nd CLEAR cycle -> aout=bout=busy=clr_done=0 at once, FSM=IDLE, all regs 0, no clr_done pulse.
- clr_req held high for 10 cycles (DEPTH=4) -> exactly two clears. busy is high for cycles 1-4 and 7-10, with clr_done at cycles 5 and 11. Cycle 6 is an IDLE cycle that accepts the second request.
